// File: rtl/fc_stream_arbiter.sv
// Two-requester front end for a shared fully-connected engine: grants whole N-in/M-out transactions.
// Build option FC_ARB_FIXED_PRIO_EN: requester 0 always wins a tie instead of round-robin.
module fc_stream_arbiter #(
  parameter int N = 8,
  parameter int M = 16,
  parameter int T = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [T-1:0] in0_data,
  input  logic         in1_valid,
  output logic         in1_ready,
  input  logic [T-1:0] in1_data,
  output logic         out0_valid,
  input  logic         out0_ready,
  output logic [T-1:0] out0_data,
  output logic         out1_valid,
  input  logic         out1_ready,
  output logic [T-1:0] out1_data,
  output logic         core_in_valid,
  input  logic         core_in_ready,
  output logic [T-1:0] core_in_data,
  input  logic         core_out_valid,
  output logic         core_out_ready,
  input  logic [T-1:0] core_out_data,
  output logic         owner,
  output logic         busy
);

  localparam int MAX_NM = (N > M) ? N : M;
  localparam int CW = $clog2(MAX_NM) + 1;
  localparam logic [CW-1:0] LAST_IN  = CW'(N - 1);
  localparam logic [CW-1:0] LAST_OUT = CW'(M - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FEED  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]    state;
  logic          last_grant;
  logic [CW-1:0] cnt;
  logic          grant_next;
  logic          in_fire;
  logic          out_fire;

  assign in_fire  = core_in_valid & core_in_ready;
  assign out_fire = core_out_valid & core_out_ready;
  assign busy     = (state != IDLE);

  // A lone requester is granted directly; only a tie consults the policy.
  always_comb begin
`ifdef FC_ARB_FIXED_PRIO_EN
    grant_next = ~in0_valid;
`else
    if (in0_valid && in1_valid) begin
      grant_next = ~last_grant;
    end else begin
      grant_next = ~in0_valid;
    end
`endif
  end

  always_comb begin
    core_in_valid  = 1'b0;
    core_in_data   = '0;
    in0_ready      = 1'b0;
    in1_ready      = 1'b0;
    core_out_ready = 1'b0;
    out0_valid     = 1'b0;
    out0_data      = '0;
    out1_valid     = 1'b0;
    out1_data      = '0;
    case (state)
      FEED: begin
        core_in_valid = owner ? in1_valid : in0_valid;
        core_in_data  = owner ? in1_data : in0_data;
        in0_ready     = ~owner & core_in_ready;
        in1_ready     = owner & core_in_ready;
      end
      DRAIN: begin
        core_out_ready = owner ? out1_ready : out0_ready;
        if (owner) begin
          out1_valid = core_out_valid;
          out1_data  = core_out_data;
        end else begin
          out0_valid = core_out_valid;
          out0_data  = core_out_data;
        end
      end
      default: begin
      end
    endcase
  end

  // owner and last_grant reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b1;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in0_valid || in1_valid) begin
            owner <= grant_next;
            state <= FEED;
          end
        end
        FEED: begin
          if (in_fire) begin
            if (cnt == LAST_IN) begin
              cnt   <= '0;
              state <= DRAIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (cnt == LAST_OUT) begin
              cnt        <= '0;
              last_grant <= owner;
              state      <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
